// File: rtl/ise_pkg.sv
// Shared ISE definitions: colour classes, round size and the result-scheduler state encoding.
package ise_pkg;

  localparam logic [1:0] COLOR_R = 2'd0;
  localparam logic [1:0] COLOR_G = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;

  localparam int unsigned IMAGE_NUM  = 32;
  localparam int unsigned IMAGE_SIZE = 128;

  typedef enum logic [1:0] {
    COLLECT,
    SCAN,
    EMIT,
    DONE
  } sched_state_e;

endpackage

// File: rtl/ise_key_cmp.sv
// Unsigned "a less than b" on packed sort keys; the caller decides which fields the key carries.
module ise_key_cmp #(
  parameter int unsigned KEY_W = 7
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic             lt
);

  assign lt = (a < b);

endmodule

// File: rtl/ise_result_scheduler.sv
// ISE output scheduler: stores one record per image, then emits indices ordered by {colour, metric, index}.
// Build option: define ISE_SCHED_METRIC_EN to include the metric in the sort key (otherwise {colour, index}).
module ise_result_scheduler
  import ise_pkg::*;
#(
  parameter int unsigned IMAGE_NUM = ise_pkg::IMAGE_NUM,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned METRIC_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [1:0]          rec_color,
  input  logic [METRIC_W-1:0] rec_metric,
  input  logic [IDX_W-1:0]    rec_index,
  output logic                out_valid,
  output logic [1:0]          color_index,
  output logic [IDX_W-1:0]    image_out_index,
  output logic                sched_done
);

  localparam int unsigned SLOTS = 1 << IDX_W;
`ifdef ISE_SCHED_METRIC_EN
  localparam int unsigned KEY_W = 2 + METRIC_W + IDX_W;
`else
  localparam int unsigned KEY_W = 2 + IDX_W;
`endif
  localparam logic [IDX_W-1:0] LAST = IDX_W'(IMAGE_NUM - 1);

  sched_state_e state, state_next;

  logic [IDX_W-1:0] wr_cnt, scan_idx, out_cnt, best_slot;
  logic             best_valid;
  logic [KEY_W-1:0] best_key, cand_key;
  logic             cand_lt;
  logic             accept;
  logic [SLOTS-1:0] emitted;

  logic [1:0]       color_mem [SLOTS];
  logic [IDX_W-1:0] index_mem [SLOTS];

`ifdef ISE_SCHED_METRIC_EN
  logic [METRIC_W-1:0] metric_mem [SLOTS];

  always_ff @(posedge clk) begin
    if (accept) metric_mem[wr_cnt] <= rec_metric;
  end

  assign cand_key = {color_mem[scan_idx], metric_mem[scan_idx], index_mem[scan_idx]};
`else
  logic unused_metric;
  assign unused_metric = ^rec_metric;
  assign cand_key = {color_mem[scan_idx], index_mem[scan_idx]};
`endif

  assign accept = rec_valid && rec_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      color_mem[wr_cnt] <= rec_color;
      index_mem[wr_cnt] <= rec_index;
    end
  end

  ise_key_cmp #(.KEY_W(KEY_W)) u_key_cmp (
    .a  (cand_key),
    .b  (best_key),
    .lt (cand_lt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rec_ready  = 1'b0;
    case (state)
      COLLECT: begin
        rec_ready = 1'b1;
        if (rec_valid && wr_cnt == LAST) state_next = SCAN;
      end
      SCAN:    if (scan_idx == LAST) state_next = EMIT;
      EMIT:    state_next = (out_cnt == LAST) ? DONE : SCAN;
      DONE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt          <= '0;
      scan_idx        <= '0;
      out_cnt         <= '0;
      best_slot       <= '0;
      best_valid      <= 1'b0;
      best_key        <= '0;
      emitted         <= '0;
      out_valid       <= 1'b0;
      color_index     <= COLOR_R;
      image_out_index <= '0;
      sched_done      <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      sched_done <= 1'b0;
      case (state)
        COLLECT: begin
          scan_idx   <= '0;
          best_valid <= 1'b0;
          if (accept) begin
            wr_cnt          <= wr_cnt + 1'b1;
            emitted[wr_cnt] <= 1'b0;
          end
        end
        SCAN: begin
          // Strict less-than keeps the earlier slot when two keys tie.
          if (!emitted[scan_idx] && (!best_valid || cand_lt)) begin
            best_valid <= 1'b1;
            best_key   <= cand_key;
            best_slot  <= scan_idx;
          end
          scan_idx <= (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
        end
        EMIT: begin
          out_valid          <= 1'b1;
          color_index        <= color_mem[best_slot];
          image_out_index    <= index_mem[best_slot];
          emitted[best_slot] <= 1'b1;
          out_cnt            <= out_cnt + 1'b1;
          best_valid         <= 1'b0;
          scan_idx           <= '0;
        end
        DONE: begin
          sched_done <= 1'b1;
          wr_cnt     <= '0;
          out_cnt    <= '0;
          emitted    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
